// File: rtl/amm_sdram_arbiter_if.sv
// Avalon-MM bundle shared by the two requester ports and the SDRAM controller port.
// "master" is the side that issues commands; "slave" is the side that accepts them.
interface amm_sdram_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_sdram_arbiter.sv
// Two-port round-robin Avalon-MM arbiter in front of the SDRAM controller.
// Port 0 is the user module, port 1 the PCIe bridge. Commands are registered
// toward the controller; an in-order tag FIFO routes read beats back to the
// port that issued each read.
module amm_sdram_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  amm_sdram_arbiter_if.slave   s0,
  amm_sdram_arbiter_if.slave   s1,
  amm_sdram_arbiter_if.master  m,
  output logic [15:0]          o_debug_flag
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic                r_grant_port;
  logic [ADDR_W-1:0]   r_m_address;
  logic [DATA_W-1:0]   r_m_writedata;
  logic [BE_W-1:0]     r_m_byteenable;
  logic                r_m_read;
  logic                r_m_write;

  logic [MAX_PEND-1:0] r_tag;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;

  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [15:0]         r_debug;

  logic                w_full;
  logic                w_empty;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_grant;
  logic                w_grant_port;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_head;

  assign w_full   = (r_count == CNT_W'(MAX_PEND));
  assign w_empty  = (r_count == '0);
  assign w_elig0  = s0.write | (s0.read & ~w_full);
  assign w_elig1  = s1.write | (s1.read & ~w_full);
  assign w_push   = w_accept & r_m_read;
  assign w_pop    = m.readdatavalid & ~w_empty;
  assign w_head   = r_tag[r_rd_ptr];

  // Next-state logic: round-robin grant in IDLE, wait for the controller in ISSUE.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig0 && w_elig1) begin
          w_grant      = 1'b1;
          w_grant_port = ~r_last_grant;
        end else if (w_elig0) begin
          w_grant      = 1'b1;
          w_grant_port = 1'b0;
        end else if (w_elig1) begin
          w_grant      = 1'b1;
          w_grant_port = 1'b1;
        end
        if (w_grant) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!m.waitrequest) begin
          w_accept     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register plus the registered command presented to the controller;
  // fields are frozen for the whole ISSUE phase so they stay stable under stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_grant_port   <= 1'b0;
      r_m_address    <= '0;
      r_m_writedata  <= '0;
      r_m_byteenable <= '0;
      r_m_read       <= 1'b0;
      r_m_write      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last_grant   <= w_grant_port;
        r_grant_port   <= w_grant_port;
        r_m_address    <= w_grant_port ? s1.address    : s0.address;
        r_m_writedata  <= w_grant_port ? s1.writedata  : s0.writedata;
        r_m_byteenable <= w_grant_port ? s1.byteenable : s0.byteenable;
        r_m_read       <= w_grant_port ? s1.read       : s0.read;
        r_m_write      <= w_grant_port ? s1.write      : s0.write;
      end else if (w_accept) begin
        r_m_read  <= 1'b0;
        r_m_write <= 1'b0;
      end
    end
  end

  // In-order tag FIFO of requester ids for reads the controller has accepted;
  // a beat arriving with nothing outstanding is dropped and flagged sticky.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= r_grant_port;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (m.readdatavalid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Steer each read beat to the port at the FIFO head with one cycle of latency;
  // the other port's data register holds its last value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_pop & ~w_head;
      r_rvalid1 <= w_pop &  w_head;
      if (w_pop && !w_head) begin
        r_rdata0 <= m.readdata;
      end
      if (w_pop && w_head) begin
        r_rdata1 <= m.readdata;
      end
    end
  end

  // Debug word is registered so it reads all-zero straight out of reset,
  // trailing the live status by one cycle afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_debug <= '0;
    end else begin
      r_debug <= {r_err, 3'b000, 5'(r_count), 3'b000, r_state, r_last_grant, 1'b0};
    end
  end

  assign s0.waitrequest   = ~(w_accept & ~r_grant_port);
  assign s1.waitrequest   = ~(w_accept &  r_grant_port);
  assign s0.readdata      = r_rdata0;
  assign s1.readdata      = r_rdata1;
  assign s0.readdatavalid = r_rvalid0;
  assign s1.readdatavalid = r_rvalid1;

  assign m.address    = r_m_address;
  assign m.writedata  = r_m_writedata;
  assign m.byteenable = r_m_byteenable;
  assign m.read       = r_m_read;
  assign m.write      = r_m_write;

  assign o_debug_flag = r_debug;

endmodule

// File: tb/tb_amm_sdram_arbiter.sv
// Directed testbench for amm_sdram_arbiter: reset values, single read,
// alternating writes, interleaved read return, FIFO-full blocking,
// controller stall and reset with reads outstanding.
module tb_amm_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] debugFlag;
  int          checks;
  int          errors;

  amm_sdram_arbiter_if #(.ADDR_W(25), .DATA_W(32)) s0If ();
  amm_sdram_arbiter_if #(.ADDR_W(25), .DATA_W(32)) s1If ();
  amm_sdram_arbiter_if #(.ADDR_W(25), .DATA_W(32)) mIf ();

  amm_sdram_arbiter #(
    .ADDR_W  (25),
    .DATA_W  (32),
    .MAX_PEND(8)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .s0          (s0If),
    .s1          (s1If),
    .m           (mIf),
    .o_debug_flag(debugFlag)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drive one read on a port; returns whether the port saw its accepting cycle.
  task automatic issueRead(input logic port, input logic [24:0] addr, output logic acc);
    if (port) begin
      s1If.read = 1'b1; s1If.address = addr;
    end else begin
      s0If.read = 1'b1; s0If.address = addr;
    end
    tick();
    acc = port ? ~s1If.waitrequest : ~s0If.waitrequest;
    tick();
    if (port) s1If.read = 1'b0; else s0If.read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (mIf.read !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_read: got %b expected 0", mIf.read); end
    checks++; if (mIf.write !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_write: got %b expected 0", mIf.write); end
    checks++; if (mIf.address !== 25'h0) begin errors++; $display("[TB] FAIL rst_m_address: got %h expected 0", mIf.address); end
    checks++; if (mIf.byteenable !== 4'h0) begin errors++; $display("[TB] FAIL rst_m_byteenable: got %h expected 0", mIf.byteenable); end
    checks++; if (s0If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_s0_waitrequest: got %b expected 1", s0If.waitrequest); end
    checks++; if (s1If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_s1_waitrequest: got %b expected 1", s1If.waitrequest); end
    checks++; if (s0If.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_s0_rvalid: got %b expected 0", s0If.readdatavalid); end
    checks++; if (s1If.readdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_s1_readdata: got %h expected 0", s1If.readdata); end
    checks++; if (debugFlag !== 16'h0000) begin errors++; $display("[TB] FAIL rst_debug: got %h expected 0000", debugFlag); end
    reset = 1'b0;
    tick();
    checks++; if (debugFlag !== 16'h0002) begin errors++; $display("[TB] FAIL idle_debug: got %h expected 0002", debugFlag); end
  endtask

  task automatic test_single_read();
    s0If.read = 1'b1; s0If.address = 25'h100; s0If.byteenable = 4'hF;
    tick();
    checks++; if (s0If.waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL sr_s0_wait: got %b expected 0", s0If.waitrequest); end
    checks++; if (s1If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL sr_s1_wait: got %b expected 1", s1If.waitrequest); end
    checks++; if (mIf.read !== 1'b1) begin errors++; $display("[TB] FAIL sr_m_read: got %b expected 1", mIf.read); end
    checks++; if (mIf.address !== 25'h100) begin errors++; $display("[TB] FAIL sr_m_address: got %h expected 100", mIf.address); end
    tick();
    s0If.read = 1'b0;
    checks++; if (mIf.read !== 1'b0) begin errors++; $display("[TB] FAIL sr_m_read_clr: got %b expected 0", mIf.read); end
    tick();
    checks++; if (debugFlag[11:7] !== 5'd1) begin errors++; $display("[TB] FAIL sr_pend1: got %0d expected 1", debugFlag[11:7]); end
    tick();
    mIf.readdatavalid = 1'b1; mIf.readdata = 32'hDEADBEEF;
    tick();
    mIf.readdatavalid = 1'b0; mIf.readdata = 32'h0;
    checks++; if (s0If.readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL sr_s0_rvalid: got %b expected 1", s0If.readdatavalid); end
    checks++; if (s0If.readdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sr_s0_rdata: got %h expected deadbeef", s0If.readdata); end
    checks++; if (s1If.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL sr_s1_rvalid: got %b expected 0", s1If.readdatavalid); end
    tick();
    checks++; if (s0If.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL sr_s0_rvalid_pulse: got %b expected 0", s0If.readdatavalid); end
    checks++; if (debugFlag[11:7] !== 5'd0) begin errors++; $display("[TB] FAIL sr_pend0: got %0d expected 0", debugFlag[11:7]); end
  endtask

  task automatic test_alternating_writes();
    int acc0;
    int acc1;
    logic port;
    logic exp0;
    logic exp1;
    logic expWr;
    acc0 = 0;
    acc1 = 0;
    doReset();
    s0If.write = 1'b1; s0If.address = 25'h0A0; s0If.writedata = 32'hA0A0A0A0; s0If.byteenable = 4'hF;
    s1If.write = 1'b1; s1If.address = 25'h0B0; s1If.writedata = 32'hB1B1B1B1; s1If.byteenable = 4'h3;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 2 == 1) begin
        port  = (((i - 1) / 2) % 2) == 1;
        exp0  = port;
        exp1  = ~port;
        expWr = 1'b1;
      end else begin
        port  = 1'b0;
        exp0  = 1'b1;
        exp1  = 1'b1;
        expWr = 1'b0;
      end
      if (!s0If.waitrequest) acc0++;
      if (!s1If.waitrequest) acc1++;
      checks++; if (s0If.waitrequest !== exp0) begin errors++; $display("[TB] FAIL aw_s0_wait cycle %0d: got %b expected %b", i, s0If.waitrequest, exp0); end
      checks++; if (s1If.waitrequest !== exp1) begin errors++; $display("[TB] FAIL aw_s1_wait cycle %0d: got %b expected %b", i, s1If.waitrequest, exp1); end
      checks++; if (mIf.write !== expWr) begin errors++; $display("[TB] FAIL aw_m_write cycle %0d: got %b expected %b", i, mIf.write, expWr); end
      if (expWr) begin
        checks++;
        if (mIf.writedata !== (port ? 32'hB1B1B1B1 : 32'hA0A0A0A0)) begin
          errors++;
          $display("[TB] FAIL aw_m_wdata cycle %0d: got %h expected %h", i, mIf.writedata, (port ? 32'hB1B1B1B1 : 32'hA0A0A0A0));
        end
      end
    end
    s0If.write = 1'b0;
    s1If.write = 1'b0;
    checks++; if (acc0 != 2) begin errors++; $display("[TB] FAIL aw_acc0: got %0d expected 2", acc0); end
    checks++; if (acc1 != 2) begin errors++; $display("[TB] FAIL aw_acc1: got %0d expected 2", acc1); end
  endtask

  task automatic test_interleaved_reads();
    logic acc;
    doReset();
    issueRead(1'b0, 25'h010, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL ir_acc_r0: got %b expected 1", acc); end
    issueRead(1'b1, 25'h020, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL ir_acc_r1: got %b expected 1", acc); end
    issueRead(1'b0, 25'h030, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL ir_acc_r2: got %b expected 1", acc); end
    mIf.readdatavalid = 1'b1; mIf.readdata = 32'hAAAA0001;
    tick();
    mIf.readdata = 32'hBBBB0002;
    checks++; if (s0If.readdatavalid !== 1'b1 || s0If.readdata !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL ir_beatA_s0: got %b/%h expected 1/aaaa0001", s0If.readdatavalid, s0If.readdata); end
    checks++; if (s1If.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL ir_beatA_s1: got %b expected 0", s1If.readdatavalid); end
    tick();
    mIf.readdata = 32'hCCCC0003;
    checks++; if (s1If.readdatavalid !== 1'b1 || s1If.readdata !== 32'hBBBB0002) begin errors++; $display("[TB] FAIL ir_beatB_s1: got %b/%h expected 1/bbbb0002", s1If.readdatavalid, s1If.readdata); end
    checks++; if (s0If.readdatavalid !== 1'b0 || s0If.readdata !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL ir_beatB_s0_hold: got %b/%h expected 0/aaaa0001", s0If.readdatavalid, s0If.readdata); end
    tick();
    mIf.readdatavalid = 1'b0; mIf.readdata = 32'h0;
    checks++; if (s0If.readdatavalid !== 1'b1 || s0If.readdata !== 32'hCCCC0003) begin errors++; $display("[TB] FAIL ir_beatC_s0: got %b/%h expected 1/cccc0003", s0If.readdatavalid, s0If.readdata); end
    checks++; if (s1If.readdatavalid !== 1'b0 || s1If.readdata !== 32'hBBBB0002) begin errors++; $display("[TB] FAIL ir_beatC_s1_hold: got %b/%h expected 0/bbbb0002", s1If.readdatavalid, s1If.readdata); end
    tick();
    checks++; if (s0If.readdatavalid !== 1'b0 || s1If.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL ir_quiet: got %b%b expected 00", s0If.readdatavalid, s1If.readdatavalid); end
  endtask

  task automatic test_fifo_full();
    logic acc;
    int accepted;
    accepted = 0;
    doReset();
    for (int i = 0; i < 8; i++) begin
      issueRead(1'b1, 25'(32'h800 + i * 4), acc);
      if (acc) accepted++;
    end
    checks++; if (accepted != 8) begin errors++; $display("[TB] FAIL ff_accepted: got %0d expected 8", accepted); end
    s1If.read = 1'b1; s1If.address = 25'h900;
    s0If.write = 1'b1; s0If.address = 25'h040; s0If.writedata = 32'h12345678; s0If.byteenable = 4'hF;
    tick();
    checks++; if (s0If.waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL ff_write_s0_wait: got %b expected 0", s0If.waitrequest); end
    checks++; if (s1If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL ff_read_s1_wait: got %b expected 1", s1If.waitrequest); end
    checks++; if (mIf.write !== 1'b1) begin errors++; $display("[TB] FAIL ff_m_write: got %b expected 1", mIf.write); end
    tick();
    s0If.write = 1'b0;
    tick();
    checks++; if (mIf.read !== 1'b0 || s1If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL ff_stalled: got read=%b wait=%b expected read=0 wait=1", mIf.read, s1If.waitrequest); end
    mIf.readdatavalid = 1'b1; mIf.readdata = 32'h00000055;
    tick();
    mIf.readdatavalid = 1'b0; mIf.readdata = 32'h0;
    checks++; if (s1If.readdatavalid !== 1'b1 || s1If.readdata !== 32'h00000055) begin errors++; $display("[TB] FAIL ff_beat_s1: got %b/%h expected 1/00000055", s1If.readdatavalid, s1If.readdata); end
    checks++; if (mIf.read !== 1'b0) begin errors++; $display("[TB] FAIL ff_no_issue_yet: got %b expected 0", mIf.read); end
    tick();
    checks++; if (mIf.read !== 1'b1 || mIf.address !== 25'h900) begin errors++; $display("[TB] FAIL ff_ninth_issue: got %b/%h expected 1/900", mIf.read, mIf.address); end
    checks++; if (s1If.waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL ff_ninth_accept: got %b expected 0", s1If.waitrequest); end
    tick();
    s1If.read = 1'b0;
  endtask

  task automatic test_stall();
    doReset();
    mIf.waitrequest = 1'b1;
    s0If.write = 1'b1; s0If.address = 25'h1234; s0If.writedata = 32'hCAFEF00D; s0If.byteenable = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (mIf.address !== 25'h1234 || mIf.write !== 1'b1) begin errors++; $display("[TB] FAIL st_stable cycle %0d: got %h/%b expected 1234/1", i, mIf.address, mIf.write); end
      checks++; if (s0If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL st_s0_wait cycle %0d: got %b expected 1", i, s0If.waitrequest); end
      tick();
    end
    mIf.waitrequest = 1'b0;
    #1;
    checks++; if (s0If.waitrequest !== 1'b0 || s1If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL st_accept: got %b%b expected 01", s0If.waitrequest, s1If.waitrequest); end
    tick();
    s0If.write = 1'b0;
    checks++; if (s0If.waitrequest !== 1'b1 || mIf.write !== 1'b0) begin errors++; $display("[TB] FAIL st_after: got wait=%b write=%b expected 1/0", s0If.waitrequest, mIf.write); end
  endtask

  task automatic test_reset_midop();
    logic acc;
    doReset();
    issueRead(1'b0, 25'h200, acc);
    issueRead(1'b1, 25'h204, acc);
    issueRead(1'b0, 25'h208, acc);
    tick();
    checks++; if (debugFlag[11:7] !== 5'd3) begin errors++; $display("[TB] FAIL rm_pend3: got %0d expected 3", debugFlag[11:7]); end
    reset = 1'b1;
    tick();
    checks++; if (mIf.read !== 1'b0 || mIf.address !== 25'h0) begin errors++; $display("[TB] FAIL rm_m_cmd: got %b/%h expected 0/0", mIf.read, mIf.address); end
    checks++; if (s0If.waitrequest !== 1'b1 || s1If.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rm_wait: got %b%b expected 11", s0If.waitrequest, s1If.waitrequest); end
    checks++; if (debugFlag !== 16'h0000) begin errors++; $display("[TB] FAIL rm_debug_rst: got %h expected 0000", debugFlag); end
    reset = 1'b0;
    mIf.readdatavalid = 1'b1; mIf.readdata = 32'h0BADF00D;
    tick();
    mIf.readdatavalid = 1'b0; mIf.readdata = 32'h0;
    checks++; if (s0If.readdatavalid !== 1'b0 || s1If.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rm_orphan_dropped: got %b%b expected 00", s0If.readdatavalid, s1If.readdatavalid); end
    checks++; if (s0If.readdata !== 32'h0 || s1If.readdata !== 32'h0) begin errors++; $display("[TB] FAIL rm_orphan_data: got %h/%h expected 0/0", s0If.readdata, s1If.readdata); end
    tick();
    checks++; if (debugFlag !== 16'h8002) begin errors++; $display("[TB] FAIL rm_err_flag: got %h expected 8002", debugFlag); end
  endtask

  // Main sequence: park all inputs, then run each scenario in turn.
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    s0If.address = '0; s0If.read = 1'b0; s0If.write = 1'b0; s0If.writedata = '0; s0If.byteenable = '0;
    s1If.address = '0; s1If.read = 1'b0; s1If.write = 1'b0; s1If.writedata = '0; s1If.byteenable = '0;
    mIf.waitrequest = 1'b0; mIf.readdata = '0; mIf.readdatavalid = 1'b0;
    test_reset();
    test_single_read();
    test_alternating_writes();
    test_interleaved_reads();
    test_fifo_full();
    test_stall();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amm_sdram_arbiter.md
# amm_sdram_arbiter

Two-port Avalon-MM arbiter that shares the single SDRAM controller slave between the PCIe bridge master and the user module master inside the Qsys system. Round-robin grant per transaction, registered command issue, and an in-order tag FIFO that steers pipelined read data back to the requester that issued the read. Sits between both masters and the SDRAM controller; exports a status word for the user-module debug conduit.

## Interface
Parameters:
- ADDR_W, 25, byte address width of the SDRAM window (32 MB)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_PEND, 8, maximum outstanding reads (power of two, 2..16)

Ports (`x` = 0 for user module, 1 for PCIe bridge):
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- sx_address  input  ADDR_W  requester byte address
- sx_read / sx_write  input  1  request strobes (never both high)
- sx_writedata  input  DATA_W  write data
- sx_byteenable  input  DATA_W/8  byte lanes
- sx_waitrequest  output  1  low for exactly the accepting cycle
- sx_readdata  output  DATA_W  returned read data
- sx_readdatavalid  output  1  one pulse per read beat
- m_address / m_writedata / m_byteenable  output  ADDR_W / DATA_W / DATA_W/8  registered command to SDRAM controller
- m_read / m_write  output  1  registered strobes
- m_waitrequest  input  1  controller stall
- m_readdata  input  DATA_W  controller read data
- m_readdatavalid  input  1  controller read beat
- debug_flag  output  16  {err, 3'b0, pend_count[4:0], 3'b0, state[1:0], last_grant, 1'b0}

## Operation
- States: IDLE, ISSUE.
- IDLE: eligible requester = sx_write, or sx_read with tag FIFO not full. Both eligible: grant the port that is not last_grant. One eligible: grant it. Grant latches address/data/byteenable/strobe into m_* registers, sets last_grant, goes ISSUE.
- ISSUE: m_read or m_write held with stable fields. When m_waitrequest low: granted sx_waitrequest low combinationally in that cycle; m strobes cleared on the edge; read pushes grant id into tag FIFO; return to IDLE.
- sx_waitrequest is high at all other times, including ungranted port and IDLE.
- Tag FIFO: depth MAX_PEND, in-order. On m_readdatavalid, pop head id; register m_readdata into that port's sx_readdata, pulse its sx_readdatavalid. Other port's readdatavalid stays 0, readdata holds its value.
- Push and pop in same cycle: count unchanged, both take effect.
- FIFO full: reads not eligible; writes still granted.
- m_readdatavalid with FIFO empty: beat dropped, err sticky set until reset.
- Writes are not tagged; write/read ordering is the controller's order of acceptance.

## Timing
- Reset (synchronous, 1 cycle min): state IDLE, m_read/m_write 0, m_address/m_writedata 0, m_byteenable 0, sx_waitrequest 1, sx_readdatavalid 0, sx_readdata 0, FIFO empty, last_grant 1 (port 0 wins first tie), err 0, debug_flag 0.
- Reset mid-operation: in-flight command aborted, tags discarded; any later orphan beat is dropped and sets err.
- Request seen in IDLE at cycle N → m strobe high at N+1; with m_waitrequest low at N+1, sx_waitrequest low at N+1; next grant decision at N+2.
- Back-to-back: max one accepted command per 2 cycles.
- Read data: m_readdatavalid at cycle K → sx_readdatavalid at K+1 (fixed 1-cycle latency); consecutive beats every cycle supported.
- pend_count saturates never; MAX_PEND reached blocks reads only.

## Test plan
- Single read port 0, address 0x100, controller returns 0xDEADBEEF 3 cycles after accept → s0_readdatavalid one pulse with 0xDEADBEEF; s1_readdatavalid stays 0; pend_count 1→0.
- Both ports assert write continuously, m_waitrequest 0 → grants alternate 0,1,0,1; first grant port 0; each port sees exactly one waitrequest-low per accepted command.
- Interleaved reads 0,1,0 with controller returning A,B,C back-to-back → s0 gets A then C, s1 gets B, each 1 cycle after its m_readdatavalid.
- Port 1 issues 8 reads with no data returned → 9th read stalls (s1_waitrequest high), concurrent port 0 write still accepted; one beat returned → 9th read issues next IDLE.
- m_waitrequest held high 5 cycles during ISSUE → m_address/m_write stable all 5, s0_waitrequest low only in accepting cycle.
- Reset asserted with 3 reads pending, then controller returns one beat → all outputs at reset values, beat dropped, debug_flag[15] = 1.
